// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_if
// Purpose  : ID-stage handshake bundle between the pipeline and trap_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface trap_ctrl_if;
   logic [31:0] Instruction_id;
   logic [31:0] NextPC_id;
   logic        TRAP;
   logic        Stall;
   logic [31:0] RtData_id;
   logic [31:0] Cp0Data_id;
   logic        Redirect;
   logic [31:0] RedirectAddr;
   logic        Flush_if;
   logic        Flush_id;
   logic        EXL;

   modport master (
      output Instruction_id, NextPC_id, TRAP, Stall, RtData_id,
      input  Cp0Data_id, Redirect, RedirectAddr, Flush_if, Flush_id, EXL
   );

   modport slave (
      input  Instruction_id, NextPC_id, TRAP, Stall, RtData_id,
      output Cp0Data_id, Redirect, RedirectAddr, Flush_if, Flush_id, EXL
   );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Trap entry/ERET redirect logic with a minimal CP0 register set.
// Revision : 1.0  initial release
// ============================================================================
module trap_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
   parameter logic [4:0]  EXC_TR       = 5'd13
) (
   input  wire logic   clk,
   input  wire logic   reset,
   trap_ctrl_if.slave  bus
);

   localparam logic [4:0]  c_REG_COUNT   = 5'd9;
   localparam logic [4:0]  c_REG_STATUS  = 5'd12;
   localparam logic [4:0]  c_REG_CAUSE   = 5'd13;
   localparam logic [4:0]  c_REG_EPC     = 5'd14;
   localparam logic [4:0]  c_REG_TRAPCNT = 5'd22;
   localparam logic [31:0] c_ERET        = 32'h4200_0018;
   localparam logic [10:0] c_MTC0_OP     = 11'b010000_00100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAKE = 2'd1,
      RET  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_count;
   logic [31:0] r_epc;
   logic [4:0]  r_cause;
   logic        r_te;
   logic        r_exl;
   logic [7:0]  r_trapCnt;

   logic        w_act;
   logic        w_isMtc0;
   logic        w_isEret;
   logic [4:0]  w_rd;
   logic        w_takeTrap;
   logic        w_doEret;
   logic        w_write;
   logic        w_redirect;
   logic [31:0] w_redirectAddr;
   logic [31:0] w_cp0Data;

   assign w_rd       = bus.Instruction_id[15:11];
   assign w_isMtc0   = (bus.Instruction_id[31:21] == c_MTC0_OP);
   assign w_isEret   = (bus.Instruction_id == c_ERET);
   // While redirecting, the ID instruction is being flushed and must not act.
   assign w_act      = !bus.Stall && (r_state == IDLE);
   assign w_takeTrap = w_act && bus.TRAP && r_te && !r_exl;
   assign w_doEret   = w_act && w_isEret && r_exl;
   assign w_write    = w_act && w_isMtc0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_redirect     = 1'b0;
      w_redirectAddr = 32'h0;
      case (r_state)
         IDLE: begin
            if (w_takeTrap) begin
               w_nextState = TAKE;
            end else if (w_doEret) begin
               w_nextState = RET;
            end
         end
         TAKE: begin
            w_nextState    = IDLE;
            w_redirect     = 1'b1;
            w_redirectAddr = HANDLER_ADDR;
         end
         RET: begin
            w_nextState    = IDLE;
            w_redirect     = 1'b1;
            w_redirectAddr = r_epc + 32'd4;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count   <= 32'h0;
         r_epc     <= 32'h0;
         r_cause   <= 5'h0;
         r_te      <= 1'b1;
         r_exl     <= 1'b0;
         r_trapCnt <= 8'h0;
      end else begin
         r_count <= (w_write && (w_rd == c_REG_COUNT)) ? bus.RtData_id : r_count + 32'd1;
         if (w_takeTrap) begin
            r_epc   <= bus.NextPC_id - 32'd4;
            r_cause <= EXC_TR;
            r_exl   <= 1'b1;
            if (r_trapCnt != 8'hFF) begin
               r_trapCnt <= r_trapCnt + 8'd1;
            end
         end else begin
            if (w_doEret) begin
               r_exl <= 1'b0;
            end
            if (w_write) begin
               case (w_rd)
                  c_REG_STATUS:  {r_exl, r_te} <= bus.RtData_id[1:0];
                  c_REG_CAUSE:   r_cause       <= bus.RtData_id[6:2];
                  c_REG_EPC:     r_epc         <= bus.RtData_id;
                  c_REG_TRAPCNT: r_trapCnt     <= bus.RtData_id[7:0];
                  default:       ;
               endcase
            end
         end
      end
   end

   always_comb begin
      w_cp0Data = 32'h0;
      case (w_rd)
         c_REG_COUNT:   w_cp0Data = r_count;
         c_REG_STATUS:  w_cp0Data = {30'h0, r_exl, r_te};
         c_REG_CAUSE:   w_cp0Data = {25'h0, r_cause, 2'b00};
         c_REG_EPC:     w_cp0Data = r_epc;
         c_REG_TRAPCNT: w_cp0Data = {24'h0, r_trapCnt};
         default:       w_cp0Data = 32'h0;
      endcase
   end

   assign bus.Cp0Data_id   = w_cp0Data;
   assign bus.Redirect     = w_redirect;
   assign bus.RedirectAddr = w_redirectAddr;
   assign bus.Flush_if     = w_redirect;
   assign bus.Flush_id     = w_redirect;
   assign bus.EXL          = r_exl;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed scoreboard bench for trap_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

   localparam logic [31:0] c_HANDLER = 32'h0000_0180;
   localparam logic [31:0] c_TEQ     = 32'h0109_0034;
   localparam logic [31:0] c_ERET    = 32'h4200_0018;
   localparam logic [31:0] c_NOP     = 32'h0000_0000;

   typedef struct {
      int          cyc;
      int          kind;   // 0 Cp0Data_id, 1 EXL, 2 Redirect level
      int          regn;
      logic [31:0] val;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t expQ[$];
   exp_t redQ[$];
   exp_t me;

   trap_ctrl_if bus ();

   trap_ctrl #(
      .HANDLER_ADDR (c_HANDLER),
      .EXC_TR       (5'd13)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, expv, cyc);
      end
   endtask

   function automatic logic [31:0] mfc0(input int rd);
      return 32'h4000_0000 | (32'(rd) << 11);
   endfunction

   function automatic logic [31:0] mtc0(input int rd);
      return 32'h4080_0000 | (32'(rd) << 11);
   endfunction

   task automatic drive(input logic [31:0] ins, input logic trap, input logic stall,
                        input logic [31:0] npc, input logic [31:0] rt);
      bus.Instruction_id = ins;
      bus.TRAP           = trap;
      bus.Stall          = stall;
      bus.NextPC_id      = npc;
      bus.RtData_id      = rt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [31:0] ins, input logic trap, input logic stall,
                       input logic [31:0] npc, input logic [31:0] rt);
      drive(ins, trap, stall, npc, rt);
      tick();
   endtask

   task automatic expRead(input int rd, input logic [31:0] v);
      expQ.push_back('{cyc, 0, rd, v});
   endtask

   task automatic expExl(input logic v);
      expQ.push_back('{cyc, 1, 0, {31'h0, v}});
   endtask

   task automatic expRedirLevel(input logic v);
      expQ.push_back('{cyc, 2, 0, {31'h0, v}});
   endtask

   task automatic expRedir(input logic [31:0] addr);
      redQ.push_back('{cyc + 1, 0, 0, addr});
   endtask

   task automatic rd(input int r, input logic [31:0] v);
      expRead(r, v);
      step(mfc0(r), 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Monitor: checks every redirect pulse and every queued observation.
   always @(negedge clk) begin
      if (bus.Redirect === 1'b1) begin
         if (redQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected redirect: got addr %h expected no redirect (cycle %0d)",
                     bus.RedirectAddr, cyc);
         end else begin
            me = redQ.pop_front();
            chk("redirect cycle", cyc, me.cyc);
            chk("redirect addr", bus.RedirectAddr, me.val);
         end
      end else begin
         if (redQ.size() > 0 && redQ[0].cyc <= cyc) begin
            me = redQ.pop_front();
            checks++;
            errors++;
            $display("FAIL missing redirect: got none expected addr %h at cycle %0d", me.val, me.cyc);
         end
         chk("idle redirect addr", bus.RedirectAddr, 32'h0);
      end
      chk("flush_if", {31'h0, bus.Flush_if}, {31'h0, bus.Redirect});
      chk("flush_id", {31'h0, bus.Flush_id}, {31'h0, bus.Redirect});
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
         me = expQ.pop_front();
         if (me.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale expectation: got none expected %h at cycle %0d", me.val, me.cyc);
         end else if (me.kind == 0) begin
            chk($sformatf("cp0 read reg%0d", me.regn), bus.Cp0Data_id, me.val);
         end else if (me.kind == 1) begin
            chk("EXL", {31'h0, bus.EXL}, me.val);
         end else begin
            chk("redirect level", {31'h0, bus.Redirect}, me.val);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] npc;
      logic [31:0] lastEpc;
      reset = 1'b1;
      drive(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // reset state
      expExl(1'b0);
      rd(9, 32'h0);
      rd(12, 32'h1);
      rd(13, 32'h0);
      rd(14, 32'h0);
      rd(22, 32'h0);

      // trap entry
      expRedir(c_HANDLER);
      step(c_TEQ, 1'b1, 1'b0, 32'h0040_0024, 32'h0);
      expExl(1'b1);
      rd(14, 32'h0040_0020);
      rd(13, 32'h0000_0034);
      rd(22, 32'h1);

      // nested trap ignored
      step(c_TEQ, 1'b1, 1'b0, 32'h0050_0000, 32'h0);
      rd(14, 32'h0040_0020);
      rd(22, 32'h1);

      // return, then ERET with EXL clear is a NOP
      expRedir(32'h0040_0024);
      step(c_ERET, 1'b0, 1'b0, 32'h0, 32'h0);
      expExl(1'b0);
      step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
      step(c_ERET, 1'b0, 1'b0, 32'h0, 32'h0);
      step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);

      // trap held under stall
      step(c_TEQ, 1'b1, 1'b1, 32'h0000_1008, 32'h0);
      step(c_TEQ, 1'b1, 1'b1, 32'h0000_1008, 32'h0);
      expRedir(c_HANDLER);
      step(c_TEQ, 1'b1, 1'b0, 32'h0000_1008, 32'h0);
      step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
      rd(14, 32'h0000_1004);
      rd(22, 32'h2);

      // MTC0 under stall is not acted on
      step(mtc0(14), 1'b0, 1'b1, 32'h0, 32'h0000_1234);
      rd(14, 32'h0000_1004);

      expRedir(32'h0000_1008);
      step(c_ERET, 1'b0, 1'b0, 32'h0, 32'h0);
      step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);

      // traps disabled via Status.TE
      step(mtc0(12), 1'b0, 1'b0, 32'h0, 32'h0);
      rd(12, 32'h0);
      step(c_TEQ, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
      step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
      rd(22, 32'h2);
      rd(14, 32'h0000_1004);

      // write masks and unimplemented register
      step(mtc0(12), 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFD);
      rd(12, 32'h1);
      step(mtc0(13), 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
      rd(13, 32'h0000_007C);
      step(mtc0(5), 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
      rd(5, 32'h0);

      // Count write overrides increment, then wraps
      step(mtc0(9), 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE);
      rd(9, 32'hFFFF_FFFE);
      rd(9, 32'hFFFF_FFFF);
      rd(9, 32'h0000_0000);

      // 300 trap/return round trips; first one exercises EPC wrap
      lastEpc = 32'h0;
      for (int i = 0; i < 300; i++) begin
         npc = (i == 0) ? 32'h0 : 32'h0040_0000 + 32'(i) * 32'd8;
         expRedir(c_HANDLER);
         step(c_TEQ, 1'b1, 1'b0, npc, 32'h0);
         step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
         expRedir(npc);
         step(c_ERET, 1'b0, 1'b0, 32'h0, 32'h0);
         step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);
         lastEpc = npc - 32'd4;
      end
      rd(14, lastEpc);
      rd(22, 32'h0000_00FF);
      rd(13, 32'h0000_0034);

      // reset asserted while in TAKE
      drive(c_TEQ, 1'b1, 1'b0, 32'h0040_0024, 32'h0);
      tick();
      chk("redirect before reset", {31'h0, bus.Redirect}, 32'h1);
      drive(mfc0(12), 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      reset = 1'b1;
      expRedirLevel(1'b0);
      expRead(12, 32'h1);
      tick();
      expRedirLevel(1'b0);
      expRead(14, 32'h0);
      step(mfc0(14), 1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b0;
      rd(9, 32'h0);
      rd(22, 32'h0);
      repeat (3) step(c_NOP, 1'b0, 1'b0, 32'h0, 32'h0);

      chk("pending redirects", redQ.size(), 32'h0);
      chk("pending reads", expQ.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Trap responder for the 5-stage MIPS pipeline. It consumes the `TRAP` flag that the decode stage raises for TEQ/TNE/TGE/TLT (and immediate/unsigned variants), and saves the trapping PC. It then redirects fetch to a fixed handler vector and flushes the younger instructions. It also owns a minimal CP0 register set (Count, Status, Cause, EPC, TrapCnt) accessed by MFC0/MTC0, and returns from the handler on ERET.

## Interface
Parameters:
- HANDLER_ADDR, 32'h0000_0180, trap vector loaded into the PC on trap entry.
- EXC_TR, 5'd13, ExcCode written to Cause on a trap.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Instruction_id  in  32  instruction currently in ID.
- NextPC_id  in  32  PC+4 of the ID instruction.
- TRAP  in  1  trap condition true for the ID instruction.
- Stall  in  1  load-use stall; ID instruction is not advancing this cycle.
- RtData_id  in  32  forwarded rt value; MTC0 write data.
- Cp0Data_id  out  32  MFC0 read data, combinational, selected by Instruction_id[15:11].
- Redirect  out  1  PC is overridden with RedirectAddr at the next edge.
- RedirectAddr  out  32  target PC while Redirect=1, else 0.
- Flush_if  out  1  squash the IF/ID register (insert NOP).
- Flush_id  out  1  squash the ID/EX register (insert bubble).
- EXL  out  1  Status.EXL; 1 while in the handler.

## Operation
- **Instruction decode (on Instruction_id):**
  - MFC0: [31:21]=010000_00000.
  - MTC0: [31:21]=010000_00100.
  - ERET: 32'h4200_0018.
  - Register number is [15:11].
- **Valid ID instruction:** "act" = !Stall && state==IDLE.
- **CP0 registers:**
  - 9 Count: 32-bit, +1 every cycle, wraps FFFF_FFFF→0.
  - 12 Status: bit1 EXL, bit0 TE; other bits read 0.
  - 13 Cause: [6:2] ExcCode; other bits read 0.
  - 14 EPC: 32-bit.
  - 22 TrapCnt: 8-bit saturating at 8'hFF, zero-extended on read.
  - Unimplemented numbers read 0 and ignore writes.
- **MTC0 on act:** writes RtData_id. Status takes only bits[1:0]; Cause takes only [6:2]. An MTC0 to Count overrides that cycle's increment.
- **MFC0:** Cp0Data_id shows current register values, with no bypass of a same-cycle MTC0.
- **State machine:** IDLE, TAKE, RET.
  - IDLE→TAKE when act && TRAP && TE && !EXL. At that edge:
    - EPC←NextPC_id−4.
    - Cause.ExcCode←EXC_TR.
    - EXL←1.
    - TrapCnt+1 (saturating).
  - TRAP with EXL=1 or TE=0 is ignored: no state change, instruction proceeds as NOP.
  - IDLE→RET when act && ERET && EXL. EXL←0 at that edge.
  - ERET with EXL=0 is a NOP.
  - TAKE→IDLE and RET→IDLE unconditionally after one cycle.
- **Outputs in TAKE:** Redirect=1, RedirectAddr=HANDLER_ADDR, Flush_if=1, Flush_id=1.
- **Outputs in RET:** Redirect=1, RedirectAddr=EPC+4 (resume after trap), Flush_if=1, Flush_id=1.
- **Outputs in IDLE:** Redirect, Flush_if and Flush_id are 0.
- **Ignored inputs in TAKE/RET:** TRAP, ERET and MTC0 are ignored because the ID instruction is being flushed. Count still increments.
- **Arithmetic:** EPC±4 uses 32-bit modulo arithmetic.

## Timing
- **Reset values:**
  - State IDLE.
  - Count=0, EPC=0, Cause=0, TrapCnt=0.
  - Status.TE=1, Status.EXL=0.
  - All outputs 0 except Cp0Data_id, which follows the registers.
- **Trap latency:** trap in ID at cycle N (sampled at edge N→N+1); Redirect/Flush asserted throughout N+1. The PC holds HANDLER_ADDR after edge N+1→N+2.
- **ERET latency:** same, with RedirectAddr=EPC+4 in N+1.
- **Stall priority:** with Stall=1, TRAP, ERET and MTC0 are not acted on; they are evaluated again when Stall drops.
- **Reset mid-TAKE/RET:** Redirect and Flush drop immediately (asynchronously); there is no partial redirect.
- **Redirect pulse:** exactly one cycle wide; it is never asserted on two consecutive cycles.

## Test plan
- **Trap entry:** after reset, TEQ with TRAP=1, NextPC_id=0x0040_0024, Stall=0 → next cycle Redirect=1, RedirectAddr=0x180, Flush_if=Flush_id=1. Afterwards EPC=0x0040_0020, EXL=1, Cause=13<<2, TrapCnt=1.
- **Trap under stall:** TRAP=1 with Stall=1 for 2 cycles, then Stall=0 → exactly one Redirect pulse, one cycle after Stall falls; EPC is captured once.
- **Return:** ERET while EXL=1, EPC=0x0040_0020 → next cycle RedirectAddr=0x0040_0024, Redirect=1; EXL=0 afterwards. A second ERET with EXL=0 → no Redirect.
- **Nested and disabled traps:** TRAP while EXL=1 → no Redirect, EPC unchanged. MTC0 reg12 with RtData=0, then TRAP → no Redirect, TrapCnt unchanged.
- **CP0 access:**
  - MTC0 reg9 = 0xFFFF_FFFE, then MFC0 reg9 on the following cycles → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 (wrap).
  - MFC0 reg 5 → 0.
  - 300 taken traps → TrapCnt reads 0xFF.
- **Reset mid-operation:** assert reset during TAKE → Redirect=0 immediately; Status reads 0x1, EPC reads 0.
